// File: rtl/regfile_32x64_pkg.sv
// Shared constants and read-mux helper for the 32 x 64-bit register file.
// X31 is the hardwired zero register.
package regfile_32x64_pkg;

    localparam int              REG_WIDTH  = 64;
    localparam int              NUM_REGS   = 32;
    localparam int              REG_ADDR_W = 5;
    localparam logic [4:0]      ZERO_REG   = 5'd31;

    // Balanced 16:1 single-bit mux built from 2:1 levels; select bit 0 steers the first level.
    function automatic logic mux16(input logic [15:0] d, input logic [3:0] s);
        logic [7:0] l1;
        logic [3:0] l2;
        logic [1:0] l3;
        for (int i = 0; i < 8; i++) l1[i] = s[0] ? d[2*i+1]  : d[2*i];
        for (int i = 0; i < 4; i++) l2[i] = s[1] ? l1[2*i+1] : l1[2*i];
        for (int i = 0; i < 2; i++) l3[i] = s[2] ? l2[2*i+1] : l2[2*i];
        return s[3] ? l3[1] : l3[0];
    endfunction

endpackage

// File: rtl/regfile_32x64_row.sv
// One architectural register: WIDTH-bit flop bank with load enable and asynchronous clear.
// The top instantiates it once per writable register.
module regfile_row #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignment so every row samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/regfile_32x64.sv
// 32 x 64-bit register file: two combinational read ports with write-through bypass,
// one write port, X31 hardwired to zero, asynchronous active-high clear.
module regfile_32x64
    import regfile_32x64_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int NREGS = NUM_REGS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  logic [WIDTH-1:0]      write_data,
    input  logic [REG_ADDR_W-1:0] read_reg1,
    input  logic [REG_ADDR_W-1:0] read_reg2,
    output logic [WIDTH-1:0]      read_data1,
    output logic [WIDTH-1:0]      read_data2
);

    logic [WIDTH-1:0] q [NREGS-1];
    logic [NREGS-2:0] we;
    logic [WIDTH-1:0] raw1, raw2;
    logic             bypass1, bypass2;
    logic             zero1, zero2;

    // One-hot write decode; address 31 has no row, so writes there simply vanish.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        we = '0;
        if (reg_write) begin
            for (int r = 0; r < NREGS - 1; r++)
                we[r] = (write_reg == REG_ADDR_W'(r));
        end
    end

    for (genvar r = 0; r < NREGS - 1; r++) begin : g_row
        regfile_row #(.WIDTH(WIDTH)) u_row (
            .clk   (clk),
            .reset (reset),
            .en    (we[r]),
            .d     (write_data),
            .q     (q[r])
        );
    end

    // Per bit: gather the register column, then two 16:1 stages and a final 2:1 per port.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [NREGS-1:0] column;

        always_comb begin
            column = '0;
            for (int r = 0; r < NREGS - 1; r++)
                column[r] = q[r][b];
        end

        assign raw1[b] = read_reg1[4] ? mux16(column[31:16], read_reg1[3:0])
                                      : mux16(column[15:0],  read_reg1[3:0]);
        assign raw2[b] = read_reg2[4] ? mux16(column[31:16], read_reg2[3:0])
                                      : mux16(column[15:0],  read_reg2[3:0]);
    end

    assign bypass1 = reg_write && (write_reg == read_reg1) && (write_reg != ZERO_REG);
    assign bypass2 = reg_write && (write_reg == read_reg2) && (write_reg != ZERO_REG);
    assign zero1   = reset || (read_reg1 == ZERO_REG);
    assign zero2   = reset || (read_reg2 == ZERO_REG);

    // Reset and the zero register override the bypass.
    assign read_data1 = zero1 ? '0 : (bypass1 ? write_data : raw1);
    assign read_data2 = zero2 ? '0 : (bypass2 ? write_data : raw2);

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed self-checking bench for regfile_32x64 with hand-computed expected values.
`timescale 1ns/100ps
module tb_regfile_32x64;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [63:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [63:0] read_data1;
    logic [63:0] read_data2;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] STRIDE = 64'h0101_0101_0101_0101;

    regfile_32x64 dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge, well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [63:0] d);
        reg_write  = 1'b1;
        write_reg  = a;
        write_data = d;
        tick();
        reg_write  = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = 5'd5;
        read_reg2  = 5'd0;
        #3;
        check("reset_rd1", read_data1, 64'h0);
        check("reset_rd2", read_data2, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Basic write then read
        write(5'd5, 64'h0123_4567_89AB_CDEF);
        read_reg1 = 5'd5;
        #1 check("basic_x5", read_data1, 64'h0123_4567_89AB_CDEF);

        // Zero register: same cycle and next cycle
        reg_write  = 1'b1;
        write_reg  = 5'd31;
        write_data = 64'hFFFF_FFFF_FFFF_FFFF;
        read_reg2  = 5'd31;
        #1 check("x31_same_cycle", read_data2, 64'h0);
        tick();
        reg_write = 1'b0;
        #1 check("x31_next_cycle", read_data2, 64'h0);

        // Disabled write
        write(5'd7, 64'hA5);
        write_reg  = 5'd7;
        write_data = 64'h5A;
        tick();
        read_reg1 = 5'd7;
        #1 check("disabled_write_x7", read_data1, 64'hA5);

        // Bypass on both ports, then stored value after the edge
        write(5'd3, 64'h11);
        reg_write  = 1'b1;
        write_reg  = 5'd3;
        write_data = 64'h22;
        read_reg1  = 5'd3;
        read_reg2  = 5'd3;
        #1;
        check("bypass_rd1_pre", read_data1, 64'h22);
        check("bypass_rd2_pre", read_data2, 64'h22);
        tick();
        reg_write = 1'b0;
        #1;
        check("bypass_rd1_post", read_data1, 64'h22);
        check("bypass_rd2_post", read_data2, 64'h22);

        // Ports independent: port 1 bypasses, port 2 reads stored X5
        reg_write  = 1'b1;
        write_reg  = 5'd3;
        write_data = 64'h33;
        read_reg1  = 5'd3;
        read_reg2  = 5'd5;
        #1;
        check("indep_rd1_bypass", read_data1, 64'h33);
        check("indep_rd2_x5", read_data2, 64'h0123_4567_89AB_CDEF);
        tick();
        reg_write = 1'b0;

        // Async reset: fill with index, assert mid-cycle
        for (int i = 0; i < 31; i++) write(5'(i), 64'(i));
        read_reg1 = 5'd30;
        read_reg2 = 5'd17;
        #1;
        check("fill_x30", read_data1, 64'd30);
        check("fill_x17", read_data2, 64'd17);
        #1 reset = 1'b1;
        for (int a = 0; a < 32; a++) begin
            read_reg1 = 5'(a);
            read_reg2 = 5'(31 - a);
            #0.1;
            check($sformatf("async_rst_rd1_%0d", a), read_data1, 64'h0);
            check($sformatf("async_rst_rd2_%0d", a), read_data2, 64'h0);
        end

        // Write during reset: no bypass, nothing stored
        reg_write  = 1'b1;
        write_reg  = 5'd9;
        write_data = 64'hFF;
        read_reg1  = 5'd9;
        #0.5 check("rst_no_bypass", read_data1, 64'h0);
        tick();
        @(negedge clk);
        reg_write = 1'b0;
        reset     = 1'b0;
        #1 check("rst_write_ignored_x9", read_data1, 64'h0);

        // Reset raised in the same cycle as a write wins
        tick();
        reg_write  = 1'b1;
        write_reg  = 5'd10;
        write_data = 64'h77;
        #2 reset = 1'b1;
        tick();
        reg_write = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        read_reg1 = 5'd10;
        #1 check("rst_wins_x10", read_data1, 64'h0);

        // First write after reset lands at the first enabled edge
        tick();
        write(5'd4, 64'h44);
        read_reg2 = 5'd4;
        #1 check("first_write_after_rst", read_data2, 64'h44);

        // Exhaustive sweep on both ports
        for (int i = 0; i < 31; i++) write(5'(i), 64'(i) * STRIDE);
        for (int a = 0; a < 32; a++) begin
            logic [63:0] e1, e2;
            read_reg1 = 5'(a);
            read_reg2 = 5'(31 - a);
            e1 = (a == 31) ? 64'h0 : 64'(a) * STRIDE;
            e2 = (a == 0)  ? 64'h0 : 64'(31 - a) * STRIDE;
            #1;
            check($sformatf("sweep_rd1_%0d", a), read_data1, e1);
            check($sformatf("sweep_rd2_%0d", 31 - a), read_data2, e2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_32x64.md
REGFILE_32X64 -- requirements
Module: regfile_32x64

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning the data width of each register in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning the number of architectural registers; the address width is log2(NREGS) = 5.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-005 The block SHALL have port reg_write, input, 1, the write enable.
REQ-006 The block SHALL have port write_reg, input, 5, the write address.
REQ-007 The block SHALL have port write_data, input, WIDTH, the write data.
REQ-008 The block SHALL have port read_reg1, input, 5, the read port 1 address.
REQ-009 The block SHALL have port read_reg2, input, 5, the read port 2 address.
REQ-010 The block SHALL have port read_data1, output, WIDTH, the read port 1 data.
REQ-011 The block SHALL have port read_data2, output, WIDTH, the read port 2 data.

Function
REQ-012 Storage SHALL be NREGS registers of WIDTH bits (X0..X31).
REQ-013 When reg_write=1 and write_reg!=31 at a rising clk edge, X[write_reg] SHALL take write_data; all other registers SHALL hold.
REQ-014 When reg_write=0, no register SHALL change.
REQ-015 X31 SHALL be hardwired zero: writes to address 31 SHALL be discarded, and reads of address 31 SHALL return 0 regardless of any bypass.
REQ-016 Reads SHALL be combinational, with zero-cycle latency from a read_reg change to the read_data change.
REQ-017 Write-through bypass: when reg_write=1, write_reg==read_regN and write_reg!=31, read_dataN SHALL equal write_data in the same cycle, before the edge.
REQ-018 Both read ports SHALL be independent; equal addresses on both ports SHALL return identical data.
REQ-019 A read and a write to the same address in one cycle SHALL return the new value via bypass; after the edge, the stored value SHALL equal it.
REQ-020 The write address decode SHALL be one-hot 5-to-32 gated by reg_write; at most one register SHALL be enabled per cycle.
REQ-021 Read selection SHALL be a 32:1 multiplexer per bit per port; there SHALL be no priority logic and no X-propagation on a legal address.

Reset
REQ-022 Asserting reset SHALL clear X0..X30 to 0 immediately, independent of clk.
REQ-023 While reset=1, writes SHALL be ignored; read_data1 and read_data2 SHALL equal 0 for every address, with the bypass suppressed.
REQ-024 After reset deassertion, the first write SHALL occur at the first rising clk edge where reg_write=1.
REQ-025 Reset asserted mid-write, in the same cycle as a write, SHALL win: the target register SHALL read 0 afterwards.

Structure
REQ-026 A shared package SHALL hold REG_WIDTH=64, NUM_REGS=32, REG_ADDR_W=5 and ZERO_REG=5'd31.
REQ-027 The block SHALL use one sub-module, regfile_row: a WIDTH-bit register with enable and asynchronous reset, instantiated 31 times.
REQ-028 Read muxing SHALL be built from 16:1 mux stages plus a 2:1 stage per bit, generated over WIDTH; the block SHALL not use behavioural array indexing on the read path.

Verification
REQ-029 The bench SHALL cover basic write/read: reset pulse; write X5=64'h0123_4567_89AB_CDEF with reg_write=1; next cycle read_reg1=5 -> read_data1=64'h0123_4567_89AB_CDEF.
REQ-030 The bench SHALL cover the zero register: write X31=64'hFFFF_FFFF_FFFF_FFFF -> read_reg2=31 returns 0, both same cycle (no bypass) and next cycle.
REQ-031 The bench SHALL cover disabled write: X7=64'hA5; reg_write=0 with write_data=64'h5A -> X7 still reads 64'hA5.
REQ-032 The bench SHALL cover bypass: X3=64'h11; same cycle reg_write=1, write_reg=3, write_data=64'h22, read_reg1=read_reg2=3 -> both ports read 64'h22 before the edge and after it.
REQ-033 The bench SHALL cover asynchronous reset: fill X0..X30 with their index; assert reset mid-cycle -> all reads are 0 before the next edge; a write during reset is ignored.
REQ-034 The bench SHALL cover an exhaustive sweep: write X[i]=i*64'h0101_0101_0101_0101 for i=0..30, then read every address on both ports -> matches, with X31=0.
